// File: rtl/regex_cpu_pipelined_window_pkg.sv
// Shared instruction definitions for the windowed regex CPU: opcode encoding
// and field extraction from an instruction word.
package regex_cpu_pipelined_window_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ACCEPT                = 3'd0,
    OP_SPLIT                 = 3'd1,
    OP_MATCH                 = 3'd2,
    OP_JMP                   = 3'd3,
    OP_END_WITHOUT_ACCEPTING = 3'd4,
    OP_MATCH_ANY             = 3'd5,
    OP_ACCEPT_PARTIAL        = 3'd6,
    OP_NOT_MATCH             = 3'd7
  } opcode_e;

  // Words are passed zero-extended to 64 bits so one helper serves any width.
  function automatic opcode_e opcode_of(input logic [63:0] word, input int word_width);
    int msb;
    msb = word_width - 1;
    return opcode_e'(word[msb -: OPCODE_WIDTH]);
  endfunction

  function automatic logic [63:0] low_field(input logic [63:0] word, input int width);
    return word & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] char_of(input logic [63:0] word, input int char_width);
    return low_field(word, char_width);
  endfunction

  function automatic logic [63:0] target_of(input logic [63:0] word, input int pc_width);
    return low_field(word, pc_width);
  endfunction

endpackage

// File: rtl/regex_cpu_pipelined_window_pc_fifo.sv
// Small synchronous FIFO of threads with registered full/empty flags.
module pc_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push && !full_q) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
      count_d         = count_d + (DEPTH_LOG2 + 1)'(1);
    end
    if (pop && !empty_q) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d  = count_d - (DEPTH_LOG2 + 1)'(1);
    end
    full_d  = (count_d == (DEPTH_LOG2 + 1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/regex_cpu_pipelined_window.sv
// Pipelined regex thread executor over a W-character window:
// thread FIFO -> instruction fetch -> EXEC register -> OUT register.
module regex_cpu_pipelined_window
  import regex_cpu_pipelined_window_pkg::*;
#(
  parameter int PC_WIDTH              = 8,
  parameter int CHARACTER_WIDTH       = 8,
  parameter int MEMORY_WIDTH          = 16,
  parameter int MEMORY_ADDR_WIDTH     = 11,
  parameter int CC_ID_BITS            = 2,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [(1<<CC_ID_BITS)*CHARACTER_WIDTH-1:0]   current_characters,
  input  logic                                         input_pc_valid,
  output logic                                         input_pc_ready,
  input  logic [PC_WIDTH-1:0]                          input_pc,
  input  logic [CC_ID_BITS-1:0]                        input_cc_id,
  output logic                                         memory_valid,
  input  logic                                         memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                 memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                      memory_data,
  output logic                                         output_pc_valid,
  input  logic                                         output_pc_ready,
  output logic [PC_WIDTH-1:0]                          output_pc,
  output logic [CC_ID_BITS-1:0]                        output_cc_id,
  output logic                                         output_pc_is_directed_to_current,
  output logic                                         accepts,
  output logic                                         running
);

  localparam int FIFO_W = PC_WIDTH + CC_ID_BITS;
  localparam logic [CC_ID_BITS-1:0] LAST_CC = CC_ID_BITS'((1 << CC_ID_BITS) - 1);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_head;
  logic [PC_WIDTH-1:0]   head_pc;
  logic [CC_ID_BITS-1:0] head_cc;

  logic                    ready_armed_q, ready_armed_d;
  logic                    pending_q, pending_d;
  logic [PC_WIDTH-1:0]     pending_pc_q, pending_pc_d;
  logic [CC_ID_BITS-1:0]   pending_cc_q, pending_cc_d;
  logic                    exec_valid_q, exec_valid_d;
  logic [MEMORY_WIDTH-1:0] exec_data_q, exec_data_d;
  logic [PC_WIDTH-1:0]     exec_pc_q, exec_pc_d;
  logic [CC_ID_BITS-1:0]   exec_cc_q, exec_cc_d;
  logic                    split_second_q, split_second_d;
  logic                    out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0]     out_pc_q, out_pc_d;
  logic [CC_ID_BITS-1:0]   out_cc_q, out_cc_d;
  logic                    out_dir_q, out_dir_d;
  logic                    accepts_q, accepts_d;

  logic [63:0]                exec_word;
  opcode_e                    exec_op;
  logic [CHARACTER_WIDTH-1:0] exec_char, window_char;
  logic [PC_WIDTH-1:0]        exec_target;
  logic                       emit, accept_hit, out_load_ok, output_fire;
  logic [PC_WIDTH-1:0]        emit_pc;
  logic [CC_ID_BITS-1:0]      emit_cc;
  logic                       emit_dir;

  pc_fifo #(
    .WIDTH      (FIFO_W),
    .DEPTH_LOG2 (FIFO_WIDTH_POWER_OF_2)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({input_pc, input_cc_id}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_pc = fifo_head[FIFO_W-1 -: PC_WIDTH];
  assign head_cc = fifo_head[CC_ID_BITS-1:0];

  assign input_pc_ready = ready_armed_q && !fifo_full;
  assign fifo_push      = input_pc_valid && input_pc_ready;
  assign memory_valid   = !fifo_empty && !exec_valid_q && !pending_q;
  assign memory_addr    = fifo_empty ? '0 : MEMORY_ADDR_WIDTH'(head_pc);
  assign fifo_pop       = memory_valid && memory_ready;

  assign exec_word   = 64'(exec_data_q);
  assign exec_op     = opcode_of(exec_word, MEMORY_WIDTH);
  assign exec_char   = CHARACTER_WIDTH'(char_of(exec_word, CHARACTER_WIDTH));
  assign exec_target = PC_WIDTH'(target_of(exec_word, PC_WIDTH));
  assign window_char = current_characters[int'(exec_cc_q) * CHARACTER_WIDTH +: CHARACTER_WIDTH];

  assign output_fire = out_valid_q && output_pc_ready;
  assign out_load_ok = !out_valid_q || output_fire;

  // Consuming ops advance cc_id; SPLIT/JMP keep it and always stay in this window.
  always_comb begin
    emit       = 1'b0;
    accept_hit = 1'b0;
    emit_pc    = exec_pc_q + PC_WIDTH'(1);
    emit_cc    = exec_cc_q + CC_ID_BITS'(1);
    emit_dir   = (exec_cc_q != LAST_CC);
    case (exec_op)
      OP_ACCEPT, OP_ACCEPT_PARTIAL: accept_hit = 1'b1;
      OP_SPLIT: begin
        emit     = 1'b1;
        emit_cc  = exec_cc_q;
        emit_dir = 1'b1;
        if (split_second_q) emit_pc = exec_target;
      end
      OP_MATCH:     emit = (window_char == exec_char);
      OP_JMP: begin
        emit     = 1'b1;
        emit_pc  = exec_target;
        emit_cc  = exec_cc_q;
        emit_dir = 1'b1;
      end
      OP_MATCH_ANY: emit = 1'b1;
      OP_NOT_MATCH: emit = (window_char != exec_char);
      OP_END_WITHOUT_ACCEPTING: emit = 1'b0;
      default:      emit = 1'b0;
    endcase
  end

  always_comb begin
    ready_armed_d  = 1'b1;
    pending_d      = fifo_pop;
    pending_pc_d   = fifo_pop ? head_pc : pending_pc_q;
    pending_cc_d   = fifo_pop ? head_cc : pending_cc_q;
    exec_valid_d   = exec_valid_q;
    exec_data_d    = exec_data_q;
    exec_pc_d      = exec_pc_q;
    exec_cc_d      = exec_cc_q;
    split_second_d = split_second_q;
    out_valid_d    = out_valid_q && !output_fire;
    out_pc_d       = out_pc_q;
    out_cc_d       = out_cc_q;
    out_dir_d      = out_dir_q;
    accepts_d      = accepts_q || (exec_valid_q && accept_hit);

    if (exec_valid_q) begin
      if (!emit) begin
        exec_valid_d = 1'b0;
      end else if (out_load_ok) begin
        out_valid_d = 1'b1;
        out_pc_d    = emit_pc;
        out_cc_d    = emit_cc;
        out_dir_d   = emit_dir;
        if (exec_op == OP_SPLIT && !split_second_q) begin
          split_second_d = 1'b1;
        end else begin
          exec_valid_d   = 1'b0;
          split_second_d = 1'b0;
        end
      end
    end

    // EXEC is always empty when a fetch returns, since fetch requires it so.
    if (pending_q) begin
      exec_valid_d   = 1'b1;
      exec_data_d    = memory_data;
      exec_pc_d      = pending_pc_q;
      exec_cc_d      = pending_cc_q;
      split_second_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_armed_q  <= 1'b0;
      pending_q      <= 1'b0;
      pending_pc_q   <= '0;
      pending_cc_q   <= '0;
      exec_valid_q   <= 1'b0;
      exec_data_q    <= '0;
      exec_pc_q      <= '0;
      exec_cc_q      <= '0;
      split_second_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_cc_q       <= '0;
      out_dir_q      <= 1'b0;
      accepts_q      <= 1'b0;
    end else begin
      ready_armed_q  <= ready_armed_d;
      pending_q      <= pending_d;
      pending_pc_q   <= pending_pc_d;
      pending_cc_q   <= pending_cc_d;
      exec_valid_q   <= exec_valid_d;
      exec_data_q    <= exec_data_d;
      exec_pc_q      <= exec_pc_d;
      exec_cc_q      <= exec_cc_d;
      split_second_q <= split_second_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_cc_q       <= out_cc_d;
      out_dir_q      <= out_dir_d;
      accepts_q      <= accepts_d;
    end
  end

  assign output_pc_valid                  = out_valid_q;
  assign output_pc                        = out_pc_q;
  assign output_cc_id                     = out_cc_q;
  assign output_pc_is_directed_to_current = out_dir_q;
  assign accepts                          = accepts_q;
  assign running = !fifo_empty || pending_q || exec_valid_q || out_valid_q;

endmodule

// File: tb/tb_regex_cpu_pipelined_window.sv
// Scoreboard bench for regex_cpu_pipelined_window: a behavioural instruction
// model queues expected threads, scenario tasks pop and compare them.
module tb_regex_cpu_pipelined_window;

  localparam int PCW = 8;
  localparam int CW  = 8;
  localparam int MW  = 16;
  localparam int MAW = 11;
  localparam int CCB = 2;
  localparam int FP  = 2;

  typedef logic [PCW+CCB:0] exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [4*CW-1:0]  current_characters;
  logic             input_pc_valid;
  logic             input_pc_ready;
  logic [PCW-1:0]   input_pc;
  logic [CCB-1:0]   input_cc_id;
  logic             memory_valid;
  logic             mem_ready;
  logic [MAW-1:0]   memory_addr;
  logic [MW-1:0]    memory_data;
  logic             output_pc_valid;
  logic             output_pc_ready;
  logic [PCW-1:0]   output_pc;
  logic [CCB-1:0]   output_cc_id;
  logic             output_dir;
  logic             accepts;
  logic             running;

  logic [MW-1:0] prog [256];
  exp_t          sb [$];
  int            errors = 0;
  int            checks = 0;

  regex_cpu_pipelined_window #(
    .PC_WIDTH(PCW), .CHARACTER_WIDTH(CW), .MEMORY_WIDTH(MW),
    .MEMORY_ADDR_WIDTH(MAW), .CC_ID_BITS(CCB), .FIFO_WIDTH_POWER_OF_2(FP)
  ) dut (
    .clk(clk), .reset(reset), .current_characters(current_characters),
    .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
    .input_pc(input_pc), .input_cc_id(input_cc_id),
    .memory_valid(memory_valid), .memory_ready(mem_ready),
    .memory_addr(memory_addr), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
    .output_pc(output_pc), .output_cc_id(output_cc_id),
    .output_pc_is_directed_to_current(output_dir),
    .accepts(accepts), .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memory_valid && mem_ready) memory_data <= prog[memory_addr[PCW-1:0]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [MW-1:0] enc(input logic [2:0] op, input logic [7:0] arg);
    return {op, 5'b0, arg};
  endfunction

  // Reference behaviour of one thread against the current window.
  function automatic void model(input logic [PCW-1:0] pc, input logic [CCB-1:0] cc);
    logic [MW-1:0] w;
    logic [2:0]    op;
    logic [7:0]    arg, c;
    logic          dir;
    w   = prog[pc];
    op  = w[15:13];
    arg = w[7:0];
    c   = current_characters[cc*8 +: 8];
    dir = (cc != 2'd3);
    case (op)
      3'd1: begin
        sb.push_back({pc + 8'd1, cc, 1'b1});
        sb.push_back({arg, cc, 1'b1});
      end
      3'd2: if (c == arg) sb.push_back({pc + 8'd1, cc + 2'd1, dir});
      3'd3: sb.push_back({arg, cc, 1'b1});
      3'd5: sb.push_back({pc + 8'd1, cc + 2'd1, dir});
      3'd7: if (c != arg) sb.push_back({pc + 8'd1, cc + 2'd1, dir});
      default: ;
    endcase
  endfunction

  task automatic send(input logic [PCW-1:0] pc, input logic [CCB-1:0] cc);
    int n = 0;
    while (!input_pc_ready && n < 50) begin @(negedge clk); n++; end
    input_pc_valid = 1'b1;
    input_pc       = pc;
    input_cc_id    = cc;
    model(pc, cc);
    @(negedge clk);
    input_pc_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (output_pc_valid) begin got = 1'b1; break; end
    end
  endtask

  task automatic ack();
    output_pc_ready = 1'b1;
    @(negedge clk);
    output_pc_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; input_pc_valid = 1'b0; input_pc = '0; input_cc_id = '0;
    mem_ready = 1'b1; output_pc_ready = 1'b0; memory_data = '0;
    current_characters = 32'h64636261;
    for (int i = 0; i < 256; i++) prog[i] = enc(3'd4, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (input_pc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b wanted 1", input_pc_ready); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running: got %b wanted 0", running); end
    checks++; if (memory_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_memvalid: got %b wanted 0", memory_valid); end
    checks++; if (output_pc_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outvalid: got %b wanted 0", output_pc_valid); end
    checks++; if (accepts !== 1'b0) begin errors++; $display("[TB] FAIL reset_accepts: got %b wanted 0", accepts); end
  endtask

  task automatic test_match();
    int   lat;
    exp_t e, obs;
    prog[8'h10] = enc(3'd2, "b");
    input_pc_valid = 1'b1; input_pc = 8'h10; input_cc_id = 2'd1;
    model(8'h10, 2'd1);
    @(posedge clk);
    @(negedge clk);
    input_pc_valid = 1'b0;
    lat = 0;
    while (!output_pc_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL match_latency: got %0d cycles wanted 3", lat); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {output_pc, output_cc_id, output_dir};
    checks++; if (!output_pc_valid || obs !== e) begin errors++; $display("[TB] FAIL match_out: got %h wanted %h", obs, e); end
    ack();
  endtask

  task automatic test_mismatch();
    bit saw = 1'b0;
    int n = 0;
    prog[8'h10] = enc(3'd2, "c");
    send(8'h10, 2'd1);
    prog[8'h51] = enc(3'd4, 8'h00);
    send(8'h51, 2'd2);
    while (running && n < 30) begin
      @(negedge clk); n++;
      if (output_pc_valid) saw = 1'b1;
    end
    checks++; if (saw || sb.size() != 0) begin errors++; $display("[TB] FAIL drop_no_output: got output=%b queued=%0d wanted none", saw, sb.size()); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL drop_running: got %b wanted 0", running); end
  endtask

  task automatic test_wrap();
    bit   got;
    exp_t e, obs;
    prog[8'h20] = enc(3'd2, "d");
    prog[8'hFF] = enc(3'd5, 8'h00);
    send(8'h20, 2'd3);
    wait_out(20, got);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {output_pc, output_cc_id, output_dir};
    checks++; if (!got || obs !== e) begin errors++; $display("[TB] FAIL wrap_cc_last: got %h wanted %h", obs, e); end
    ack();
    send(8'hFF, 2'd0);
    wait_out(20, got);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {output_pc, output_cc_id, output_dir};
    checks++; if (!got || obs !== e) begin errors++; $display("[TB] FAIL wrap_pc: got %h wanted %h", obs, e); end
    ack();
  endtask

  task automatic test_split();
    bit   got, stable;
    exp_t e, obs, first;
    prog[8'h05] = enc(3'd1, 8'h40);
    send(8'h05, 2'd2);
    wait_out(20, got);
    first = {output_pc, output_cc_id, output_dir};
    stable = got;
    repeat (4) begin
      @(negedge clk);
      if (!output_pc_valid || {output_pc, output_cc_id, output_dir} !== first) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("[TB] FAIL split_hold: got %h wanted %h held", {output_pc, output_cc_id, output_dir}, first); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (first !== e) begin errors++; $display("[TB] FAIL split_first: got %h wanted %h", first, e); end
    ack();
    wait_out(20, got);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {output_pc, output_cc_id, output_dir};
    checks++; if (!got || obs !== e) begin errors++; $display("[TB] FAIL split_second: got %h wanted %h", obs, e); end
    ack();
  endtask

  task automatic test_back_to_back();
    bit   got;
    exp_t e, obs;
    prog[8'h50] = enc(3'd3, 8'h60);
    send(8'h20, 2'd3);
    send(8'h50, 2'd3);
    send(8'hFF, 2'd1);
    for (int i = 0; i < 3; i++) begin
      wait_out(30, got);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      obs = {output_pc, output_cc_id, output_dir};
      checks++; if (!got || obs !== e) begin errors++; $display("[TB] FAIL b2b_out%0d: got %h wanted %h", i, obs, e); end
      ack();
    end
  endtask

  task automatic test_accept();
    bit   got;
    int   n = 0;
    exp_t e, obs;
    prog[8'h30] = enc(3'd0, 8'h00);
    prog[8'h31] = enc(3'd7, "x");
    send(8'h30, 2'd1);
    while (running && n < 30) begin @(negedge clk); n++; end
    checks++; if (accepts !== 1'b1) begin errors++; $display("[TB] FAIL accept_set: got %b wanted 1", accepts); end
    send(8'h31, 2'd0);
    wait_out(20, got);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    obs = {output_pc, output_cc_id, output_dir};
    checks++; if (!got || obs !== e) begin errors++; $display("[TB] FAIL not_match_out: got %h wanted %h", obs, e); end
    ack();
    repeat (5) @(negedge clk);
    checks++; if (accepts !== 1'b1) begin errors++; $display("[TB] FAIL accept_sticky: got %b wanted 1", accepts); end
  endtask

  task automatic test_reset_mid_stream();
    logic [MAW-1:0] addr0;
    bit             saw = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h70 + 8'(i), 2'd0);
    checks++; if (input_pc_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b wanted 0", input_pc_ready); end
    addr0 = memory_addr;
    repeat (3) @(negedge clk);
    checks++; if (!memory_valid || addr0 !== 11'h070 || memory_addr !== 11'h070) begin
      errors++; $display("[TB] FAIL full_addr_hold: got %h then %h valid=%b wanted 070", addr0, memory_addr, memory_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({memory_valid, output_pc_valid, accepts, running, input_pc_ready} !== 5'b0) begin
      errors++; $display("[TB] FAIL midreset_flags: got mv=%b ov=%b acc=%b run=%b rdy=%b wanted all 0",
                         memory_valid, output_pc_valid, accepts, running, input_pc_ready);
    end
    checks++; if (output_pc !== 8'h00 || output_cc_id !== 2'd0 || memory_addr !== 11'h000) begin
      errors++; $display("[TB] FAIL midreset_fields: got pc=%h cc=%h addr=%h wanted 0", output_pc, output_cc_id, memory_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    sb.delete();
    repeat (10) begin
      @(negedge clk);
      if (output_pc_valid || memory_valid) saw = 1'b1;
    end
    checks++; if (saw || running !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got activity=%b running=%b wanted 0", saw, running); end
    checks++; if (input_pc_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b wanted 1", input_pc_ready); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_wrap();
    test_split();
    test_back_to_back();
    test_accept();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
